// File: rtl/bram_feature_loader.sv
// Streams 128-bit feature words into 16 interleaved BRAM banks (word n -> bank n%16, address n/16).
// Optional build define LOADER_BYTE_SWAP_EN byte-reverses every word on the write port.
module bram_feature_loader #(
  parameter int NUM_BANK = 16,
  parameter int AW       = 9,
  parameter int DW       = 128
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                iStart,
  input  logic [13:0]         iLen,
  input  logic                iValid,
  output logic                oReady,
  input  logic [DW-1:0]       iData,
  output logic [NUM_BANK-1:0] oEna,
  output logic [AW-1:0]       oAddra,
  output logic [NUM_BANK-1:0] oWea,
  output logic [DW-1:0]       oDia,
  output logic                oBusy,
  output logic                oDone
);

  localparam int BW = $clog2(NUM_BANK);
  localparam int LW = 14;
  localparam logic [LW-1:0] MAX_LEN = LW'(NUM_BANK * (2 ** AW));

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e              state_q, state_d;
  logic [LW-1:0]       remaining_q, remaining_d;
  logic [BW-1:0]       bank_q, bank_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [NUM_BANK-1:0] ena_q, ena_d;
  logic [AW-1:0]       addra_q, addra_d;
  logic [DW-1:0]       dia_q, dia_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;

  function automatic logic [DW-1:0] formatWord(input logic [DW-1:0] w);
    logic [DW-1:0] r;
`ifdef LOADER_BYTE_SWAP_EN
    for (int i = 0; i < DW / 8; i++) begin
      r[8*i +: 8] = w[DW-8-8*i +: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  // Write strobes, ready and done are all registered so they line up with the
  // state that produced them: the final strobe shares its cycle with oDone.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bank_d      = bank_q;
    addr_d      = addr_q;
    ena_d       = '0;
    addra_d     = addra_q;
    dia_d       = dia_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          remaining_d = (iLen > MAX_LEN) ? MAX_LEN : iLen;
          bank_d      = '0;
          addr_d      = '0;
          state_d     = (iLen == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (iValid) begin
          ena_d       = {{(NUM_BANK-1){1'b0}}, 1'b1} << bank_q;
          addra_d     = addr_q;
          dia_d       = formatWord(iData);
          bank_d      = bank_q + BW'(1);
          if (bank_q == '1) begin
            addr_d = addr_q + AW'(1);
          end
          remaining_d = remaining_q - LW'(1);
          if (remaining_q == LW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == LOAD);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      bank_q      <= '0;
      addr_q      <= '0;
      ena_q       <= '0;
      addra_q     <= '0;
      dia_q       <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      ena_q       <= ena_d;
      addra_q     <= addra_d;
      dia_q       <= dia_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign oReady = ready_q;
  assign oBusy  = ready_q;
  assign oDone  = done_q;
  assign oEna   = ena_q;
  assign oWea   = ena_q;
  assign oAddra = addra_q;
  assign oDia   = dia_q;

endmodule

// File: tb/tb_bram_feature_loader.sv
// Directed bench for bram_feature_loader: bank/address interleave, bubbles, clamping,
// zero-length loads, mid-load reset and the optional byte swap (LOADER_BYTE_SWAP_EN).
module tb_bram_feature_loader;

  logic         clk = 1'b0;
  logic         rstn;
  logic         iStart;
  logic [13:0]  iLen;
  logic         iValid;
  logic         oReady;
  logic [127:0] iData;
  logic [15:0]  oEna;
  logic [8:0]   oAddra;
  logic [15:0]  oWea;
  logic [127:0] oDia;
  logic         oBusy;
  logic         oDone;

  int testsRun = 0;
  int testsFailed = 0;

  logic [15:0]  lastWea;
  logic [8:0]   lastAddra;
  logic [127:0] lastDia;

  bram_feature_loader dut (
    .clk    (clk),
    .rstn   (rstn),
    .iStart (iStart),
    .iLen   (iLen),
    .iValid (iValid),
    .oReady (oReady),
    .iData  (iData),
    .oEna   (oEna),
    .oAddra (oAddra),
    .oWea   (oWea),
    .oDia   (oDia),
    .oBusy  (oBusy),
    .oDone  (oDone)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] expData(input logic [127:0] w);
    logic [127:0] r;
`ifdef LOADER_BYTE_SWAP_EN
    r = {<<8{w}};
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called just after a falling edge; inputs change on falling edges, outputs are checked there too.
  task automatic applyStimulus(input int len, input int validMode, input int expWrites,
                               input int stopAt, input logic [127:0] dataBase);
    int  n;
    int  cyc;
    logic sent;
    n   = 0;
    cyc = 0;
    checkOutput("idle_ready", 128'(oReady), 128'(0));
    iStart = 1'b1;
    iLen   = 14'(len);
    iValid = 1'b0;
    @(negedge clk);
    iStart = 1'b0;
    if (expWrites == 0) begin
      checkOutput("zero_done", 128'(oDone), 128'(1));
      checkOutput("zero_ready", 128'(oReady), 128'(0));
      checkOutput("zero_wea", 128'(oWea), 128'(0));
      @(negedge clk);
      checkOutput("zero_done_off", 128'(oDone), 128'(0));
      checkOutput("zero_ready_off", 128'(oReady), 128'(0));
      checkOutput("zero_wea_off", 128'(oWea), 128'(0));
      return;
    end
    checkOutput("start_ready", 128'(oReady), 128'(1));
    checkOutput("start_busy", 128'(oBusy), 128'(1));
    checkOutput("start_wea", 128'(oWea), 128'(0));
    while (n < stopAt && cyc < 3 * stopAt + 10) begin
      iValid = (validMode == 0) || (cyc % 2 == 0);
      iData  = dataBase + 128'(n);
      sent   = iValid;
      @(negedge clk);
      if (sent) begin
        checkOutput("wea", 128'(oWea), 128'(1) << (n % 16));
        checkOutput("ena", 128'(oEna), 128'(1) << (n % 16));
        checkOutput("addra", 128'(oAddra), 128'(n / 16));
        checkOutput("dia", oDia, expData(dataBase + 128'(n)));
        lastWea   = oWea;
        lastAddra = oAddra;
        lastDia   = oDia;
        n++;
      end else begin
        checkOutput("bubble_wea", 128'(oWea), 128'(0));
      end
      checkOutput("done", 128'(oDone), 128'(n == expWrites));
      checkOutput("ready", 128'(oReady), 128'(n != expWrites));
      cyc++;
    end
    iValid = 1'b0;
    if (n < stopAt) begin
      checkOutput("timeout_words", 128'(n), 128'(stopAt));
      return;
    end
    if (stopAt == expWrites) begin
      iValid = 1'b1;
      iData  = '1;
      @(negedge clk);
      checkOutput("extra_wea", 128'(oWea), 128'(0));
      checkOutput("extra_done", 128'(oDone), 128'(0));
      checkOutput("extra_ready", 128'(oReady), 128'(0));
      checkOutput("extra_busy", 128'(oBusy), 128'(0));
      iValid = 1'b0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 128'(oReady), 128'(0));
    checkOutput({tag, "_busy"}, 128'(oBusy), 128'(0));
    checkOutput({tag, "_done"}, 128'(oDone), 128'(0));
    checkOutput({tag, "_ena"}, 128'(oEna), 128'(0));
    checkOutput({tag, "_wea"}, 128'(oWea), 128'(0));
    checkOutput({tag, "_addra"}, 128'(oAddra), 128'(0));
    checkOutput({tag, "_dia"}, oDia, 128'(0));
  endtask

  initial begin
    rstn   = 1'b0;
    iStart = 1'b0;
    iLen   = '0;
    iValid = 1'b0;
    iData  = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rstn = 1'b1;
    @(negedge clk);

    applyStimulus(16, 0, 16, 16, 128'(0));
    checkOutput("len16_last_wea", 128'(lastWea), 128'(16'h8000));
    checkOutput("len16_last_addra", 128'(lastAddra), 128'(0));

    applyStimulus(40, 1, 40, 40, 128'(0));
    checkOutput("len40_last_wea", 128'(lastWea), 128'(16'h0080));
    checkOutput("len40_last_addra", 128'(lastAddra), 128'(2));

    applyStimulus(0, 0, 0, 0, 128'(0));

    applyStimulus(9000, 0, 8192, 8192, 128'(0));
    checkOutput("clamp_last_wea", 128'(lastWea), 128'(16'h8000));
    checkOutput("clamp_last_addra", 128'(lastAddra), 128'(511));

    applyStimulus(32, 0, 32, 5, 128'(0));
    iStart = 1'b1;
    iLen   = 14'd16;
    @(negedge clk);
    iStart = 1'b0;
    checkOutput("mid_start_ready", 128'(oReady), 128'(1));
    checkOutput("mid_start_wea", 128'(oWea), 128'(0));
    checkOutput("mid_start_done", 128'(oDone), 128'(0));
    iValid = 1'b1;
    iData  = 128'd5;
    @(negedge clk);
    checkOutput("mid_word5_wea", 128'(oWea), 128'(16'h0020));
    checkOutput("mid_word5_addra", 128'(oAddra), 128'(0));
    iData = 128'd6;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    iValid = 1'b0;
    rstn   = 1'b1;
    @(negedge clk);
    applyStimulus(16, 0, 16, 16, 128'(0));

    applyStimulus(1, 0, 1, 1, 128'h000102030405060708090a0b0c0d0e0f);
`ifdef LOADER_BYTE_SWAP_EN
    checkOutput("swap_dia", lastDia, 128'h0f0e0d0c0b0a09080706050403020100);
`else
    checkOutput("plain_dia", lastDia, 128'h000102030405060708090a0b0c0d0e0f);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
